cnt_argmax: RTL and testbench



---
 rtl/cnt_argmax.sv | 99 +++++++++
 tb/tb_cnt_argmax.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/cnt_argmax.sv
// rtl/cnt_argmax.sv - snapshot count bus, serially scan for the largest entry, flag low confidence
module cnt_argmax #(
    parameter int MODN = 30,
    parameter int ADDW = 14,
    parameter int IDXW = 5
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [MODN*ADDW-1:0] cnt_bus,
    input  logic                 start,
    input  logic [ADDW-1:0]      min_cnt,
    output logic                 busy,
    output logic                 result_valid,
    output logic [IDXW-1:0]      result_idx,
    output logic [ADDW-1:0]      result_max,
    output logic                 result_low
);

    localparam int PW = $clog2(MODN);

    typedef enum logic {
        IDLE,
        SCAN
    } state_t;

    state_t          state;
    logic [ADDW-1:0] snap [0:MODN-1];
    logic [PW-1:0]   ptr;
    logic [ADDW-1:0] best_val;
    logic [IDXW-1:0] best_idx;
    logic [ADDW-1:0] floor_cnt;

    logic [ADDW-1:0] cur_val;
    logic [ADDW-1:0] nxt_val;
    logic [IDXW-1:0] nxt_idx;

    // Strict compare keeps the earliest index on ties.
    always_comb begin
        cur_val = snap[ptr];
        nxt_val = best_val;
        nxt_idx = best_idx;
        if (cur_val > best_val) begin
            nxt_val = cur_val;
            nxt_idx = IDXW'(ptr);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= IDLE;
            busy         <= 1'b0;
            result_valid <= 1'b0;
            result_idx   <= '0;
            result_max   <= '0;
            result_low   <= 1'b0;
            ptr          <= '0;
            best_val     <= '0;
            best_idx     <= '0;
            floor_cnt    <= '0;
            for (int i = 0; i < MODN; i++) begin
                snap[i] <= '0;
            end
        end else begin
            result_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        for (int i = 0; i < MODN; i++) begin
                            snap[i] <= cnt_bus[i*ADDW +: ADDW];
                        end
                        floor_cnt <= min_cnt;
                        best_val  <= cnt_bus[ADDW-1:0];
                        best_idx  <= '0;
                        ptr       <= PW'(1);
                        busy      <= 1'b1;
                        state     <= SCAN;
                    end
                end
                SCAN: begin
                    best_val <= nxt_val;
                    best_idx <= nxt_idx;
                    ptr      <= ptr + PW'(1);
                    // Last entry: publish the result including this final comparison.
                    if (ptr == PW'(MODN - 1)) begin
                        result_idx   <= nxt_idx;
                        result_max   <= nxt_val;
                        result_low   <= (nxt_val < floor_cnt);
                        result_valid <= 1'b1;
                        busy         <= 1'b0;
                        ptr          <= '0;
                        state        <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cnt_argmax.sv
// tb/tb_cnt_argmax.sv - directed self-checking bench for cnt_argmax
module tb_cnt_argmax;

    localparam int MODN = 30;
    localparam int ADDW = 14;
    localparam int IDXW = 5;

    logic                 clk;
    logic                 rst_n;
    logic [MODN*ADDW-1:0] cnt_bus;
    logic                 start;
    logic [ADDW-1:0]      min_cnt;
    logic                 busy;
    logic                 result_valid;
    logic [IDXW-1:0]      result_idx;
    logic [ADDW-1:0]      result_max;
    logic                 result_low;

    int checks;
    int errors;
    logic [ADDW-1:0] ent [0:MODN-1];

    cnt_argmax #(.MODN(MODN), .ADDW(ADDW), .IDXW(IDXW)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .cnt_bus(cnt_bus),
        .start(start),
        .min_cnt(min_cnt),
        .busy(busy),
        .result_valid(result_valid),
        .result_idx(result_idx),
        .result_max(result_max),
        .result_low(result_low)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic fill(input int val);
        for (int i = 0; i < MODN; i++) ent[i] = ADDW'(val);
    endtask

    function automatic logic [MODN*ADDW-1:0] pack();
        logic [MODN*ADDW-1:0] b;
        for (int i = 0; i < MODN; i++) b[i*ADDW +: ADDW] = ent[i];
        return b;
    endfunction

    task automatic check_reset_outputs(input string tag);
        check({tag, "_busy"}, int'(busy), 0);
        check({tag, "_valid"}, int'(result_valid), 0);
        check({tag, "_idx"}, int'(result_idx), 0);
        check({tag, "_max"}, int'(result_max), 0);
        check({tag, "_low"}, int'(result_low), 0);
    endtask

    // Starts (unless chained) and walks cycles c+1..c+MODN at negedges.
    // clear_k: cycle at which cnt_bus is zeroed; restart_k: cycle at which start is re-pulsed;
    // chain: assert start in cycle c+MODN for a back-to-back scan.
    task automatic run_scan(input string tag, input int minv, input bit chained_in,
                            input int exp_idx, input int exp_max, input int exp_low,
                            input int clear_k, input int restart_k, input bit chain);
        if (!chained_in) begin
            @(negedge clk);
            cnt_bus = pack();
            min_cnt = ADDW'(minv);
            start   = 1'b1;
        end
        for (int k = 1; k <= MODN; k++) begin
            @(negedge clk);
            start = (k == restart_k) || (chain && k == MODN);
            if (k == clear_k) cnt_bus = '0;
            if (k == 1 || k == MODN - 1 || k == MODN)
                check($sformatf("%s_busy_c%0d", tag, k), int'(busy), (k <= MODN - 1) ? 1 : 0);
            check($sformatf("%s_valid_c%0d", tag, k), int'(result_valid), (k == MODN) ? 1 : 0);
        end
        check({tag, "_idx"}, int'(result_idx), exp_idx);
        check({tag, "_max"}, int'(result_max), exp_max);
        check({tag, "_low"}, int'(result_low), exp_low);
        if (!chain) begin
            for (int k = 1; k <= 6; k++) begin
                @(negedge clk);
                start = 1'b0;
                check($sformatf("%s_post_valid%0d", tag, k), int'(result_valid), 0);
                check($sformatf("%s_post_busy%0d", tag, k), int'(busy), 0);
            end
            check({tag, "_hold_idx"}, int'(result_idx), exp_idx);
        end
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        rst_n   = 1'b0;
        start   = 1'b0;
        cnt_bus = '0;
        min_cnt = '0;
        repeat (2) @(negedge clk);
        check_reset_outputs("reset");
        rst_n = 1'b1;

        fill(10); ent[17] = 14'd500;
        run_scan("main", 100, 0, 17, 500, 0, 0, 0, 0);

        fill(0); ent[3] = 14'h3FFF; ent[25] = 14'h3FFF;
        run_scan("tie", 0, 0, 3, 16383, 0, 0, 0, 0);

        fill(0); ent[29] = 14'd1;
        run_scan("last", 0, 0, 29, 1, 0, 0, 0, 0);

        fill(0); ent[0] = 14'd1;
        run_scan("first", 0, 0, 0, 1, 0, 0, 0, 0);

        fill(5); ent[8] = 14'd99;
        run_scan("low100", 100, 0, 8, 99, 1, 0, 0, 0);
        run_scan("low99", 99, 0, 8, 99, 0, 0, 0, 0);

        fill(0);
        run_scan("zeros", 1, 0, 0, 0, 1, 0, 0, 0);

        fill(10); ent[17] = 14'd500;
        run_scan("isolate", 100, 0, 17, 500, 0, 1, 5, 0);

        fill(10); ent[17] = 14'd500;
        run_scan("b2b_a", 100, 0, 17, 500, 0, 0, 0, 1);
        fill(0); ent[4] = 14'd77;
        cnt_bus = cnt_bus;
        run_scan("b2b_b", 100, 1, 17, 500, 0, 0, 0, 0);

        fill(1); ent[12] = 14'd900;
        @(negedge clk);
        cnt_bus = pack();
        min_cnt = 14'd50;
        start   = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            start = 1'b0;
        end
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check_reset_outputs("midrst");
        for (int k = 1; k <= 25; k++) begin
            @(negedge clk);
            check($sformatf("midrst_novalid%0d", k), int'(result_valid), 0);
        end

        run_scan("after_rst", 50, 0, 12, 900, 0, 0, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
